// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: FSM states, op codes and
// error-cause bit positions, plus the request error classifier.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_ILLEGAL  = 2;
    localparam int ERR_W        = 3;

    // One bit per rejection reason; any set bit rejects the request.
    function automatic logic [ERR_W-1:0] err_cause(
        input logic [31:0] addr,
        input logic        rd,
        input logic        wr,
        input int          depth
    );
        logic [ERR_W-1:0] cause;
        logic [31:0]      limit;
        limit                = 32'(depth);
        cause                = '0;
        cause[ERR_MISALIGN]  = (addr[1:0] != 2'b00);
        cause[ERR_RANGE]     = ({2'b00, addr[31:2]} >= limit);
        cause[ERR_ILLEGAL]   = rd & wr;
        return cause;
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter that paces the wait states of one request; the zero
// flag marks the cycle whose decrement brings the count to zero.
module dmem_wait_counter #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [W-1:0] INIT = W'(LATENCY - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= INIT;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY cycles to a
// one-cycle ready_o pulse. Define DMEM_RESPONDER_STATS_EN to add op counters.
//
// state | meaning
// IDLE  | waiting for MemRead_i/MemWrite_i
// WAIT  | request latched, wait states running
// RESP  | ready_o pulse; a write commits on the edge leaving this state
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        ready_o,
    output logic        err_o,
    output logic [31:0] data_o
`ifdef DMEM_RESPONDER_STATS_EN
    ,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o,
    output logic [15:0] err_count_o
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t        state;
    op_t           op_q;
    op_t           sel_op;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] sel_idx;
    logic [31:0]   data_q;
    logic          err_q;
    logic          sel_err;
    logic          in_err;
    logic          accept;
    logic          enter_resp;
    logic          cnt_zero;
    logic          commit;
    logic [31:0]   mem [DEPTH];

    assign in_err     = |err_cause(addr_i, MemRead_i, MemWrite_i, DEPTH);
    assign accept     = (state == IDLE) && (MemRead_i || MemWrite_i);
    assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && cnt_zero);
    assign commit     = (state == RESP) && (op_q == OP_WR) && !err_q;

    // With LATENCY=1 the response is built on the accept edge, so take the live inputs.
    always_comb begin
        if (state == IDLE) begin
            sel_idx = addr_i[AW+1:2];
            sel_op  = (MemWrite_i && !MemRead_i) ? OP_WR : OP_RD;
            sel_err = in_err;
        end else begin
            sel_idx = idx_q;
            sel_op  = op_q;
            sel_err = err_q;
        end
    end

    dmem_wait_counter #(
        .LATENCY(LATENCY)
    ) u_wait_counter (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (accept),
        .dec  (state == WAIT),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            ready_o <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= '0;
            op_q    <= OP_RD;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_o <= enter_resp;
            err_o   <= enter_resp && sel_err;
            if (enter_resp) begin
                if (sel_err) begin
                    data_o <= '0;
                end else if (sel_op == OP_RD) begin
                    data_o <= mem[sel_idx];
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= sel_op;
                        idx_q  <= addr_i[AW+1:2];
                        data_q <= data_i;
                        err_q  <= in_err;
                        busy_o <= 1'b1;
                        state  <= (LATENCY > 1) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[idx_q] <= data_q;
        end
    end

`ifdef DMEM_RESPONDER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_count_o  <= '0;
            wr_count_o  <= '0;
            err_count_o <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                err_count_o <= err_count_o + 16'd1;
            end else if (op_q == OP_RD) begin
                rd_count_o <= rd_count_o + 32'd1;
            end else begin
                wr_count_o <= wr_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 5) checked every
// cycle against a transaction-level model, plus literal expectations.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [2:0]  busy;
    logic [2:0]  ready;
    logic [2:0]  err;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] dout  [3];
`ifdef DMEM_RESPONDER_STATS_EN
    logic [31:0] rdc [3];
    logic [31:0] wrc [3];
    logic [15:0] erc [3];
`endif

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (128),
            .LATENCY (g == 0 ? 1 : (g == 1 ? 2 : 5))
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst[g]),
            .MemRead_i  (rd[g]),
            .MemWrite_i (wr[g]),
            .addr_i     (addr[g]),
            .data_i     (wdata[g]),
            .busy_o     (busy[g]),
            .ready_o    (ready[g]),
            .err_o      (err[g]),
            .data_o     (dout[g])
`ifdef DMEM_RESPONDER_STATS_EN
            ,
            .rd_count_o (rdc[g]),
            .wr_count_o (wrc[g]),
            .err_count_o(erc[g])
`endif
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
    endfunction

    function automatic logic exp_error(input logic [31:0] a, input logic r, input logic w);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd128) || (r && w);
    endfunction

    task automatic cmp(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, k, $time, got, exp);
        end
    endtask

    // Model: ph = edges since acceptance (0 idle); ready is due when ph == LATENCY.
    int          ph     [3];
    logic        m_err  [3];
    logic        m_rd   [3];
    int          m_idx  [3];
    logic [31:0] m_data [3];
    logic [31:0] exp_q  [3];
    logic [31:0] mmem   [3][128];
    logic [31:0] m_rdc  [3];
    logic [31:0] m_wrc  [3];
    logic [15:0] m_erc  [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int prev;
            prev = ph[k];
            if (rst[k]) begin
                ph[k] = 0;
                exp_q[k] = 0;
                m_rdc[k] = 0;
                m_wrc[k] = 0;
                m_erc[k] = 0;
                for (int i = 0; i < 128; i++) mmem[k][i] = 0;
            end else begin
                if (prev == 0) begin
                    if (rd[k] || wr[k]) begin
                        m_err[k]  = exp_error(addr[k], rd[k], wr[k]);
                        m_rd[k]   = !wr[k];
                        m_idx[k]  = int'(addr[k][8:2]);
                        m_data[k] = wdata[k];
                        ph[k]     = 1;
                    end
                end else if (prev == lat_of(k)) begin
                    if (m_err[k]) m_erc[k] = m_erc[k] + 1;
                    else if (m_rd[k]) m_rdc[k] = m_rdc[k] + 1;
                    else begin
                        m_wrc[k] = m_wrc[k] + 1;
                        mmem[k][m_idx[k]] = m_data[k];
                    end
                    ph[k] = 0;
                end else begin
                    ph[k] = prev + 1;
                end
                if (ph[k] == lat_of(k) && prev != lat_of(k)) begin
                    if (m_err[k]) exp_q[k] = 0;
                    else if (m_rd[k]) exp_q[k] = mmem[k][m_idx[k]];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                logic exp_rdy;
                exp_rdy = (ph[k] != 0) && (ph[k] == lat_of(k));
                cmp("busy",  k, 32'(busy[k]),  32'(ph[k] != 0));
                cmp("ready", k, 32'(ready[k]), 32'(exp_rdy));
                cmp("err",   k, 32'(err[k]),   32'(exp_rdy && m_err[k]));
                cmp("data",  k, dout[k], exp_q[k]);
`ifdef DMEM_RESPONDER_STATS_EN
                cmp("rd_count",  k, rdc[k], m_rdc[k]);
                cmp("wr_count",  k, wrc[k], m_wrc[k]);
                cmp("err_count", k, 32'(erc[k]), 32'(m_erc[k]));
`endif
            end
        end
    end

    // One request; optionally scrambles the inputs while busy and during RESP.
    task automatic txn(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit scr,
                       output logic e, output logic [31:0] q, output int lat);
        bit ok;
        @(negedge clk);
        rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
        ok = 1'b0;
        for (int n = 0; n < 8 && !ok; n++) begin
            @(posedge clk); #1;
            ok = busy[k];
        end
        lat = 0; e = 1'bx; q = 'x;
        if (!ok) begin
            cmp("accept_timeout", k, 32'd0, 32'd1);
            rd[k] = 0; wr[k] = 0;
            return;
        end
        lat = 1;
        while (!ready[k] && lat < 20) begin
            @(negedge clk);
            if (scr) begin
                rd[k] = ($urandom & 1) != 0;
                wr[k] = ($urandom & 1) != 0;
                addr[k] = $urandom;
                wdata[k] = $urandom;
            end else begin
                rd[k] = 0; wr[k] = 0;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!ready[k]) cmp("ready_timeout", k, 32'd0, 32'd1);
        e = err[k];
        q = dout[k];
        if (scr) begin
            rd[k] = 1; wr[k] = 0; addr[k] = 32'h4; wdata[k] = $urandom;
            @(posedge clk); #1;
        end
        rd[k] = 0; wr[k] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] q;
        int          lat;
        rst = 3'b111; rd = 0; wr = 0;
        for (int k = 0; k < 3; k++) begin addr[k] = 0; wdata[k] = 0; end
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 3'b000;
        cmp("rst_busy",  1, 32'(busy[1]),  32'd0);
        cmp("rst_ready", 1, 32'(ready[1]), 32'd0);
        cmp("rst_data",  1, dout[1], 32'd0);

        txn(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, e, q, lat);
        cmp("wr10_lat", 1, 32'(lat), 32'd2); cmp("wr10_err", 1, 32'(e), 32'd0);
        txn(1, 1, 0, 32'h10, 32'h0, 0, e, q, lat);
        cmp("rd10_lat", 1, 32'(lat), 32'd2); cmp("rd10_data", 1, q, 32'hDEADBEEF);
        cmp("rd10_err", 1, 32'(e), 32'd0);
        txn(1, 1, 0, 32'h13, 32'h0, 0, e, q, lat);
        cmp("rd13_err", 1, 32'(e), 32'd1); cmp("rd13_data", 1, q, 32'd0);
        txn(1, 1, 0, 32'h10, 32'h0, 0, e, q, lat);
        cmp("rd10b_data", 1, q, 32'hDEADBEEF);
        txn(1, 0, 1, 32'h200, 32'h12345678, 0, e, q, lat);
        cmp("wr200_err", 1, 32'(e), 32'd1);
        txn(1, 1, 0, 32'h0, 32'h0, 0, e, q, lat);
        cmp("rd0_data", 1, q, 32'd0); cmp("rd0_err", 1, 32'(e), 32'd0);
        txn(1, 1, 1, 32'h20, 32'hFFFFFFFF, 0, e, q, lat);
        cmp("rdwr20_err", 1, 32'(e), 32'd1);
        txn(1, 1, 0, 32'h20, 32'h0, 0, e, q, lat);
        cmp("rd20_data", 1, q, 32'd0);
        txn(1, 0, 1, 32'h1FC, 32'hCAFEF00D, 0, e, q, lat);
        cmp("wr1fc_err", 1, 32'(e), 32'd0);
        txn(1, 1, 0, 32'h1FC, 32'h0, 0, e, q, lat);
        cmp("rd1fc_data", 1, q, 32'hCAFEF00D);
        txn(1, 0, 1, 32'h40, 32'h11112222, 1, e, q, lat);
        cmp("wr40s_lat", 1, 32'(lat), 32'd2); cmp("wr40s_err", 1, 32'(e), 32'd0);
        txn(1, 1, 0, 32'h40, 32'h0, 1, e, q, lat);
        cmp("rd40s_data", 1, q, 32'h11112222);

        // Reset in the WAIT cycle of a write: it must vanish without a pulse.
        @(negedge clk);
        wr[1] = 1; addr[1] = 32'h8; wdata[1] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        cmp("mr_accept", 1, 32'(busy[1]), 32'd1);
        wr[1] = 0;
        @(negedge clk);
        rst[1] = 1;
        @(posedge clk); #1;
        cmp("mr_busy",  1, 32'(busy[1]),  32'd0);
        cmp("mr_ready", 1, 32'(ready[1]), 32'd0);
`ifdef DMEM_RESPONDER_STATS_EN
        cmp("mr_rdc", 1, rdc[1], 32'd0);
        cmp("mr_wrc", 1, wrc[1], 32'd0);
        cmp("mr_erc", 1, 32'(erc[1]), 32'd0);
`endif
        @(negedge clk);
        rst[1] = 0;
        repeat (3) @(posedge clk);
        txn(1, 1, 0, 32'h8, 32'h0, 0, e, q, lat);
        cmp("rd8_data", 1, q, 32'd0);

        txn(0, 0, 1, 32'h10, 32'h0BADF00D, 1, e, q, lat);
        cmp("l1_wr_lat", 0, 32'(lat), 32'd1);
        txn(0, 1, 0, 32'h10, 32'h0, 1, e, q, lat);
        cmp("l1_rd_lat", 0, 32'(lat), 32'd1); cmp("l1_rd_data", 0, q, 32'h0BADF00D);

        txn(2, 0, 1, 32'h7C, 32'h5555AAAA, 1, e, q, lat);
        cmp("l5_wr_lat", 2, 32'(lat), 32'd5);
        txn(2, 1, 0, 32'h7C, 32'h0, 1, e, q, lat);
        cmp("l5_rd_lat", 2, 32'(lat), 32'd5); cmp("l5_rd_data", 2, q, 32'h5555AAAA);

        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory interface.
- Accepts one read or write request at a time and inserts a configurable number of wait states.
- Signals completion with a one-cycle ready_o pulse carrying read data or an error flag.
- Sits behind the load/store path as the multi-cycle replacement target for the zero-latency data memory. It lets the team exercise stall handling in upcoming CPU revisions.

Parameters:
- DEPTH, 128, number of 32-bit words stored; power of two, 2 to 4096.
- LATENCY, 2, cycles from request acceptance to the ready_o pulse; must be at least 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- MemRead_i  input  1  read request.
- MemWrite_i  input  1  write request.
- addr_i  input  32  byte address.
- data_i  input  32  write data.
- busy_o  output  1  a request is in flight; new requests are ignored.
- ready_o  output  1  one-cycle completion pulse.
- err_o  output  1  valid with ready_o; the request was rejected.
- data_o  output  32  read data; valid with ready_o, held until the next completion.

Behaviour:
- Reset: one clock and reset domain; reset is synchronous and active-high on rst_i, sampled only on the rising clk_i edge.
  - Reset forces state IDLE and wait counter 0.
  - busy_o=0, ready_o=0, err_o=0, data_o=0; all DEPTH words cleared to 0.
- State IDLE: a request is valid when MemRead_i or MemWrite_i is high. On the edge where one is seen:
  - latch addr_i, data_i and the op; load counter with LATENCY-1.
  - go to WAIT if LATENCY>1, otherwise RESP.
- State WAIT: busy_o=1; counter decrements each cycle; move to RESP when the counter reaches 0.
- State RESP: busy_o=1 and ready_o=1 for exactly one cycle, then IDLE.
  - Write: the memory word updates on the edge leaving RESP.
  - Read: data_o shows mem[word] during RESP and holds afterwards.
- Timing: for a request sampled at edge N, ready_o is high in the cycle after edge N+LATENCY-1. This gives LATENCY cycles of latency and LATENCY+1 cycles of occupancy.
  - A back-to-back request is sampled on the edge that returns to IDLE or later.
  - IDLE is one cycle minimum; a request held during RESP is not accepted early.
- Word index: addr[2+log2(DEPTH)-1 : 2].
- Error conditions; each gives err_o=1 with ready_o, no memory write, and data_o forced to 0:
  - addr[1:0] != 0 (misaligned).
  - addr[31:2] >= DEPTH (out of range).
  - MemRead_i and MemWrite_i both high (illegal op).
- Requests and input changes while busy_o=1 are ignored; latched values are used.
- Read-after-write to the same word in consecutive transactions returns the new data.
- Reset asserted mid-transaction abandons it: no write, no ready_o pulse.

Optional Feature:
- Macro: DMEM_RESPONDER_STATS_EN.
- When defined:
  - Adds outputs rd_count_o[31:0], wr_count_o[31:0] and err_count_o[15:0].
  - Each increments on the RESP cycle of a completed read, completed write or errored request respectively. An errored request counts only in err_count_o.
  - Counters wrap modulo 2^width and clear on reset.
- When undefined: these ports and their registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - the state encoding (IDLE, WAIT, RESP).
  - the op encoding (OP_RD, OP_WR).
  - the error-cause localparams (ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL), for bench checking.
- One sub-module, dmem_wait_counter: a loadable down-counter with a zero flag, sized from LATENCY.
- Storage array and FSM stay in dmem_responder.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10, then read 0x10 with LATENCY=2. Required: each ready_o is exactly 2 cycles after acceptance; the read returns 0xDEADBEEF; err_o=0.
- Read from 0x13. Required: ready_o with err_o=1, data_o=0. Then read 0x10: must still return 0xDEADBEEF.
- Write 0x12345678 to address 4*DEPTH (0x200 at default). Required: err_o=1. A subsequent read of word 0 shows no corruption.
- Assert MemRead_i and MemWrite_i together at 0x20. Required: err_o=1, no write. Read 0x20 returns 0.
- Change addr_i and data_i every cycle while busy_o=1. Required: only the latched request executes; no extra ready_o pulses. Repeat with LATENCY=1 (ready_o 1 cycle after acceptance) and LATENCY=5.
- Assert rst_i during WAIT of a write of 0xA5A5A5A5 to 0x8. Required: no ready_o, busy_o=0 the next cycle. Read 0x8 returns 0. With DMEM_RESPONDER_STATS_EN, all counters read 0.
